spi_host_master: RTL and testbench

SPI master that drives the Logic Sniffer's SPI slave port (sclk/mosi/cs) in place of the PIC. It takes single command bytes over a valid/ready handshake and shifts each one out MSB-first. It captures the byte returned on miso during the same frame. It can also auto-poll the sniffer with a filler byte while dataReady is high, so a host-side FPGA or loopback fixture can exercise the full command/readback path.

---
 rtl/spi_host_master.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_host_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_master.sv
// SPI mode-0 host that drives the Logic Sniffer's SPI slave port.
// Each frame shifts one command byte out MSB-first on mosi and captures the
// byte the sniffer returns on miso. While auto-poll is enabled and the
// sniffer's dataReady is high, the block sends POLL_BYTE frames on its own
// so the sniffer's queued response can be drained without host involvement.
`timescale 1ns/1ps

module spi_host_master #(
    parameter int          CS_SETUP  = 5,
    parameter int          SCLK_HALF = 3,
    parameter int          CS_HOLD   = 5,
    parameter int          CS_GAP    = 5,
    parameter logic [7:0]  POLL_BYTE = 8'h7F
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       auto_poll_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_poll,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    input  logic       miso,
    input  logic       data_ready
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared phase counter covers every timed state, so it is sized for
    // the longest of them.
    localparam int MAX_LEN = max2(max2(CS_SETUP, SCLK_HALF), max2(CS_HOLD, CS_GAP));
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] phase_last;
    logic             phase_done;
    logic [2:0]       bit_q;
    logic [7:0]       tx_shift_q;
    logic [7:0]       rx_shift_q;
    logic             poll_q;
    logic             ready_q;
    logic             dr_meta_q;
    logic             dr_sync_q;
    logic             start;
    logic             poll_start;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             rx_poll_q;

    // An explicit request always wins; a poll only starts when nobody asked.
    assign poll_start = !tx_valid && auto_poll_en && dr_sync_q;
    assign start      = (state_q == IDLE) && ready_q && (tx_valid || poll_start);

    // Two-flop synchroniser for the sniffer's asynchronous dataReady.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dr_meta_q <= 1'b0;
            dr_sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a two-stage shift;
            // blocking ones would collapse both flops into a single stage.
            dr_meta_q <= data_ready;
            dr_sync_q <= dr_meta_q;
        end
    end

    // Holds tx_ready low through reset and raises it from the first clock after release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Length of the current timed phase, as a last-count value.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        phase_last = '0;
        unique case (state_q)
            SETUP:     phase_last = SETUP_LAST;
            LOW, HIGH: phase_last = HALF_LAST;
            HOLD:      phase_last = HOLD_LAST;
            GAP:       phase_last = GAP_LAST;
            default:   phase_last = '0;
        endcase
    end

    assign phase_done = (cnt_q == phase_last);

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start)      state_d = SETUP;
            SETUP: if (phase_done) state_d = LOW;
            LOW:   if (phase_done) state_d = HIGH;
            HIGH:  if (phase_done) state_d = (bit_q == 3'd0) ? HOLD : LOW;
            HOLD:  if (phase_done) state_d = GAP;
            GAP:   if (phase_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM output decode: SPI pins and handshake flags follow the state directly.
    always_comb begin
        cs_n     = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        busy     = 1'b1;
        tx_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                tx_ready = ready_q;
            end
            SETUP: begin
                cs_n = 1'b0;
            end
            LOW: begin
                cs_n = 1'b0;
                mosi = tx_shift_q[7];
            end
            HIGH: begin
                cs_n = 1'b0;
                sclk = 1'b1;
                mosi = tx_shift_q[7];
            end
            HOLD: begin
                cs_n = 1'b0;
            end
            GAP: begin
                cs_n = 1'b1;
            end
            default: begin
                cs_n = 1'b1;
            end
        endcase
    end

    // Phase counter: restarts on every state change and idles at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Shift datapath: load on start, sample miso and advance at the end of each high phase.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: the shift and capture registers are reset as well; they are a
        // handful of flops, and a defined value keeps rx_data clean after reset.
        if (!reset_n) begin
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            bit_q      <= 3'd0;
            poll_q     <= 1'b0;
        end else begin
            if (start) begin
                tx_shift_q <= tx_valid ? tx_data : POLL_BYTE;
                poll_q     <= poll_start;
            end
            if ((state_q == SETUP) && phase_done) begin
                bit_q <= 3'd7;
            end
            if ((state_q == HIGH) && phase_done) begin
                rx_shift_q <= {rx_shift_q[6:0], miso};
                tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                bit_q      <= bit_q - 3'd1;
            end
        end
    end

    // Result register: publishes the captured byte as the frame's gap ends.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_poll_q  <= 1'b0;
        end else begin
            rx_valid_q <= (state_q == GAP) && phase_done;
            if ((state_q == GAP) && phase_done) begin
                rx_data_q <= rx_shift_q;
                rx_poll_q <= poll_q;
            end
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_poll  = rx_poll_q;

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master: a mode-0 slave model answers on miso,
// a pin monitor measures frame timing and collects the mosi bytes, and each
// directed step compares against hand-computed values for the default timing.
`timescale 1ns/1ps

module tb_spi_host_master;

    localparam int         CS_SETUP  = 5;
    localparam int         SCLK_HALF = 3;
    localparam int         CS_HOLD   = 5;
    localparam int         CS_GAP    = 5;
    localparam logic [7:0] POLL_BYTE = 8'h7F;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       auto_poll_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_poll;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       data_ready = 1'b0;

    spi_host_master #(
        .CS_SETUP  (CS_SETUP),
        .SCLK_HALF (SCLK_HALF),
        .CS_HOLD   (CS_HOLD),
        .CS_GAP    (CS_GAP),
        .POLL_BYTE (POLL_BYTE)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .auto_poll_en (auto_poll_en),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_poll      (rx_poll),
        .busy         (busy),
        .sclk         (sclk),
        .mosi         (mosi),
        .cs_n         (cs_n),
        .miso         (miso),
        .data_ready   (data_ready)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // Mode-0 slave: presents bit k while sclk is low before rise k+1 and keeps
    // it through that high phase, so miso only changes on sclk falling edges.
    logic [7:0] s_byte = 8'h00;
    int         s_rise = 0;
    int         miso_idx;

    always @(posedge sclk or negedge cs_n) begin
        if (!sclk) s_rise <= 0;
        else       s_rise <= s_rise + 1;
    end

    always_comb begin
        miso_idx = sclk ? (s_rise - 1) : s_rise;
        miso = 1'b0;
        if (miso_idx >= 0 && miso_idx < 8) miso = s_byte[3'(7 - miso_idx)];
    end

    // Pin monitor, sampled on the falling clock edge.
    int         frames_started = 0;
    int         cs_run = 0;
    int         cs_hi_run = 0;
    int         hi_run = 0;
    int         last_cs_low = 0;
    int         last_cs_high = 0;
    int         rises = 0;
    int         last_rises = 0;
    int         bad_hi = 0;
    int         rx_count = 0;
    int         rx_cyc = 0;
    logic [7:0] mosi_byte = 8'h00;
    logic [7:0] mosi_q[$];
    logic [7:0] rxd_q[$];
    logic       rxp_q[$];

    initial begin
        logic prev_cs;
        logic prev_sclk;
        prev_cs = 1'b1;
        prev_sclk = 1'b0;
        forever begin
            @(negedge clock);
            if (!cs_n) begin
                if (prev_cs) begin
                    frames_started = frames_started + 1;
                    last_cs_high = cs_hi_run;
                    cs_run = 0;
                    rises = 0;
                end
                cs_run = cs_run + 1;
            end else begin
                if (!prev_cs) begin
                    last_cs_low = cs_run;
                    last_rises = rises;
                    if (rises == 8) mosi_q.push_back(mosi_byte);
                    cs_hi_run = 0;
                end
                cs_hi_run = cs_hi_run + 1;
            end
            if (sclk) begin
                if (!prev_sclk) begin
                    rises = rises + 1;
                    mosi_byte = {mosi_byte[6:0], mosi};
                    hi_run = 0;
                end
                hi_run = hi_run + 1;
            end else if (prev_sclk && !cs_n) begin
                if (hi_run != SCLK_HALF) bad_hi = bad_hi + 1;
            end
            if (rx_valid) begin
                rx_count = rx_count + 1;
                rx_cyc = cyc;
                rxd_q.push_back(rx_data);
                rxp_q.push_back(rx_poll);
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Waits for the edge that takes tx_data; acc is the number of that clock edge.
    task automatic wait_accept(input string tag, output int acc);
        bit   done;
        logic r;
        done = 1'b0;
        acc = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            r = tx_ready;
            step();
            if (r) begin
                done = 1'b1;
                acc = cyc;
            end
        end
        check({tag, " accepted"}, 32'(done), 1);
    endtask

    task automatic wait_rx(input string tag, input int target);
        for (int i = 0; i < 400 && rx_count < target; i++) step();
        check({tag, " rx_valid seen"}, 32'(rx_count >= target), 1);
    endtask

    task automatic wait_frames(input string tag, input int target);
        for (int i = 0; i < 400 && frames_started < target; i++) step();
        check({tag, " frame started"}, 32'(frames_started >= target), 1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] exp_rx,
                                input logic exp_poll, input logic [7:0] exp_mosi);
        logic [7:0] d;
        logic       p;
        logic [7:0] m;
        d = (rxd_q.size() > 0) ? rxd_q.pop_front() : 8'hxx;
        p = (rxp_q.size() > 0) ? rxp_q.pop_front() : 1'bx;
        m = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'hxx;
        check({tag, " rx_data"}, 32'(d), 32'(exp_rx));
        check({tag, " rx_poll"}, 32'(p), 32'(exp_poll));
        check({tag, " mosi byte"}, 32'(m), 32'(exp_mosi));
    endtask

    initial begin
        int         acc;
        int         f0;
        int         r0;
        logic [7:0] sniff [4];
        sniff[0] = 8'h31;
        sniff[1] = 8'h41;
        sniff[2] = 8'h4C;
        sniff[3] = 8'h53;

        // ---- Reset: outputs during reset and in the first cycle after release
        #2 reset_n = 1'b0;
        #1;
        check("reset cs_n", 32'(cs_n), 1);
        check("reset sclk", 32'(sclk), 0);
        check("reset mosi", 32'(mosi), 0);
        check("reset tx_ready", 32'(tx_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset rx_valid", 32'(rx_valid), 0);
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("post-reset tx_ready", 32'(tx_ready), 1);
        check("post-reset cs_n", 32'(cs_n), 1);
        check("post-reset rx_data", 32'(rx_data), 0);
        check("post-reset rx_poll", 32'(rx_poll), 0);

        // ---- Single byte 0x02, slave answers 0xA5
        s_byte = 8'hA5;
        tx_data = 8'h02;
        tx_valid = 1'b1;
        wait_accept("single", acc);
        tx_valid = 1'b0;
        check("single busy after accept", 32'(busy), 1);
        check("single tx_ready after accept", 32'(tx_ready), 0);
        wait_rx("single", 1);
        check("single rx latency", 32'(rx_cyc - acc), 63);
        check("single cs_n low cycles", 32'(last_cs_low), 58);
        check("single sclk pulses", 32'(last_rises), 8);
        check_result("single", 8'hA5, 1'b0, 8'h02);
        check("single rx_valid one cycle", 32'(rx_valid), 0);
        check("single rx_data held", 32'(rx_data), 'hA5);
        check("single busy after frame", 32'(busy), 0);

        // ---- Back-to-back 0xC0 then 0x11 with tx_valid held throughout
        s_byte = 8'h96;
        r0 = rx_count;
        tx_data = 8'hC0;
        tx_valid = 1'b1;
        wait_accept("b2b first", acc);
        tx_data = 8'h11;
        wait_accept("b2b second", acc);
        tx_valid = 1'b0;
        wait_rx("b2b", r0 + 2);
        // cs_n stays high for the gap plus the IDLE cycle in which the next byte is taken
        check("b2b cs_n high between frames", 32'(last_cs_high), 32'(CS_GAP + 1));
        check_result("b2b frame 1", 8'h96, 1'b0, 8'hC0);
        check_result("b2b frame 2", 8'h96, 1'b0, 8'h11);
        check("b2b sclk pulses", 32'(last_rises), 8);

        // ---- Auto-poll drains "1ALS", then stops once data_ready drops
        f0 = frames_started;
        r0 = rx_count;
        s_byte = sniff[0];
        auto_poll_en = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_frames("poll", f0 + i + 1);
            s_byte = sniff[i];
            if (i == 3) data_ready = 1'b0;
            wait_rx("poll", r0 + i + 1);
        end
        repeat (100) step();
        check("poll frame count", 32'(frames_started - f0), 4);
        for (int i = 0; i < 4; i++) begin
            check_result($sformatf("poll frame %0d", i), sniff[i], 1'b1, POLL_BYTE);
        end
        auto_poll_en = 1'b0;

        // ---- Priority: explicit 0x00 and poll conditions in the same IDLE cycle
        s_byte = 8'h3C;
        data_ready = 1'b1;
        repeat (4) step();
        f0 = frames_started;
        r0 = rx_count;
        tx_data = 8'h00;
        tx_valid = 1'b1;
        auto_poll_en = 1'b1;
        wait_accept("priority", acc);
        tx_valid = 1'b0;
        wait_frames("priority poll", f0 + 2);
        data_ready = 1'b0;
        wait_rx("priority", r0 + 2);
        check_result("priority explicit", 8'h3C, 1'b0, 8'h00);
        check_result("priority poll", 8'h3C, 1'b1, POLL_BYTE);
        auto_poll_en = 1'b0;

        // ---- Reset after the 3rd sclk rise of a frame
        s_byte = 8'hC3;
        f0 = frames_started;
        tx_data = 8'hE7;
        tx_valid = 1'b1;
        wait_accept("midreset", acc);
        tx_valid = 1'b0;
        for (int i = 0; i < 200 && !(frames_started == f0 + 1 && rises >= 3); i++) step();
        check("midreset reached 3rd rise", 32'(rises), 3);
        r0 = rx_count;
        reset_n = 1'b0;
        #1;
        check("midreset cs_n", 32'(cs_n), 1);
        check("midreset sclk", 32'(sclk), 0);
        check("midreset mosi", 32'(mosi), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset tx_ready", 32'(tx_ready), 0);
        repeat (3) step();
        reset_n = 1'b1;
        repeat (80) step();
        check("midreset no rx_valid", 32'(rx_count), 32'(r0));
        check("midreset rx_data cleared", 32'(rx_data), 0);
        check("midreset truncated frame", 32'(last_rises), 3);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        wait_accept("after reset", acc);
        tx_valid = 1'b0;
        wait_rx("after reset", r0 + 1);
        check("after reset rx latency", 32'(rx_cyc - acc), 63);
        check("after reset sclk pulses", 32'(last_rises), 8);
        check("after reset cs_n low cycles", 32'(last_cs_low), 58);
        check_result("after reset", 8'hC3, 1'b0, 8'h5A);

        check("sclk high width errors", 32'(bad_hi), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
